// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcode/cmd fields,
// datapath mux selects and ARM condition codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH
  } mc_state_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Unknown cmds execute as AND; the caller suppresses their register write.
  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD: return ALU_ADD;
      CMD_SUB: return ALU_SUB;
      CMD_CMP: return ALU_SUB;
      CMD_ORR: return ALU_ORR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic cmd_legal(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP) ||
           (cmd == CMD_AND) || (cmd == CMD_ORR);
  endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register, ARM condition evaluation and the per-instruction
// latched condition result that gates architectural writes.
module cond_unit
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic       nz_we_i,
  input  logic       cv_we_i,
  input  logic       latch_en_i,
  output logic [3:0] Flags,
  output logic       CondExReg
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  logic       cond_ex;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    case (Cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (nz_we_i) flags_d[3:2] = ALUFlags[3:2];
    if (cv_we_i) flags_d[1:0] = ALUFlags[1:0];
    cond_ex_d = latch_en_i ? cond_ex : cond_ex_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign Flags     = flags_q;
  assign CondExReg = cond_ex_q;

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multicycle ARM-subset datapath.
// Define MC_MEMWAIT_EN to stall FETCH/MEMREAD/MEMWRITE on MemReady.
module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegW,
  output logic       MemW,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] Flags
);

  mc_state_e  state_q, state_d;
  logic       cond_ex_reg;
  logic       nz_we, cv_we, latch_en;
  logic       mem_ready;
  logic [3:0] cmd;
  logic       i_bit, s_bit, l_bit;
  logic       is_cmp, legal, cv_cmd, in_exec;
  logic       pc_write, ir_write, reg_w, mem_w;

`ifdef MC_MEMWAIT_EN
  assign mem_ready = MemReady;
`else
  logic mem_ready_unused;
  assign mem_ready_unused = MemReady;
  assign mem_ready        = 1'b1;
`endif

  assign cmd    = Funct[4:1];
  assign i_bit  = Funct[5];
  assign s_bit  = Funct[0];
  assign l_bit  = Funct[0];
  assign is_cmp = (cmd == CMD_CMP);
  assign legal  = cmd_legal(cmd);
  assign cv_cmd = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = i_bit ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = l_bit ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER,
      S_EXECUTEI: state_d = is_cmp ? S_FETCH : S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      S_MEMADR:   ALUSrcB = SRCB_IMM;
      S_MEMREAD:  AdrSrc  = 1'b1;
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = cond_ex_reg;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w     = cond_ex_reg;
      end
      S_EXECUTER: ALUControl = alu_decode(cmd);
      S_EXECUTEI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = alu_decode(cmd);
      end
      // Unknown cmds compute but never retire a register or PC write.
      S_ALUWB: begin
        reg_w    = cond_ex_reg & legal;
        pc_write = cond_ex_reg & legal & (Rd == 4'b1111);
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        pc_write  = cond_ex_reg;
      end
      default: ;
    endcase
  end

  // Write strobes are masked asynchronously so nothing retires during reset.
  assign PCWrite = pc_write & rst_n;
  assign IRWrite = ir_write & rst_n;
  assign RegW    = reg_w & rst_n;
  assign MemW    = mem_w & rst_n;

  assign ImmSrc = Op;
  assign RegSrc = {Op == OP_MEM, Op == OP_BR};

  assign in_exec  = (state_q == S_EXECUTER) || (state_q == S_EXECUTEI);
  assign nz_we    = in_exec & cond_ex_reg & s_bit;
  assign cv_we    = nz_we & cv_cmd;
  assign latch_en = (state_q == S_DECODE);

  cond_unit u_cond (
    .clk        (clk),
    .rst_n      (rst_n),
    .Cond       (Cond),
    .ALUFlags   (ALUFlags),
    .nz_we_i    (nz_we),
    .cv_we_i    (cv_we),
    .latch_en_i (latch_en),
    .Flags      (Flags),
    .CondExReg  (cond_ex_reg)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed and randomized checks of the multicycle controller against a
// per-instruction output-plan model of the sequencing rules.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] Cond = 4'h0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'h00;
  logic [3:0] Rd = 4'h0;
  logic [3:0] ALUFlags = 4'h0;
  logic       MemReady = 1'b0;
  logic       PCWrite, IRWrite, RegW, MemW, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
  logic [3:0] Flags;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [3:0] model_flags = 4'h0;
  logic [15:0] obs;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegW(RegW), .MemW(MemW),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl), .Flags(Flags)
  );

  assign obs = {PCWrite, IRWrite, RegW, MemW, AdrSrc, ALUSrcA,
                ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, want);
  endtask

  function automatic logic [15:0] word(input logic [1:0] op,
      input logic pcw, input logic irw, input logic regw, input logic memw,
      input logic adr, input logic srca, input logic [1:0] srcb,
      input logic [1:0] res, input logic [1:0] aluc);
    return {pcw, irw, regw, memw, adr, srca, srcb, res, op,
            (op == 2'b01), (op == 2'b10), aluc};
  endfunction

  function automatic logic cond_passes(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 2'b00;
      4'b0010: return 2'b01;
      4'b1010: return 2'b01;
      4'b1100: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Builds the expected per-cycle output words for one instruction, drives it
  // and checks every cycle; abort_at >= 0 pulls reset during that cycle.
  task automatic run_instr(input logic [3:0] cond, input logic [1:0] op,
      input logic [5:0] funct, input logic [3:0] rd, input logic [3:0] exec_fl,
      input int fwait, input int mwait, input int abort_at);
    logic [15:0] exp_q[$];
    bit          rdy_q[$];
    int          exec_idx;
    logic        ok, legal, wr;
    logic [3:0]  cmd;
    exec_idx = -1;
    cmd      = funct[4:1];
    legal    = (cmd inside {4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100});
    Cond = cond; Op = op; Funct = funct; Rd = rd;
    ok = cond_passes(cond, model_flags);
    for (int k = 0; k < fwait; k++) begin
      exp_q.push_back(word(op, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00)); rdy_q.push_back(0);
    end
    exp_q.push_back(word(op, 1, 1, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00)); rdy_q.push_back(1);
    exp_q.push_back(word(op, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00)); rdy_q.push_back(1);
    case (op)
      2'b10: begin
        exp_q.push_back(word(op, ok, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00)); rdy_q.push_back(1);
      end
      2'b01: begin
        exp_q.push_back(word(op, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00)); rdy_q.push_back(1);
        for (int k = 0; k <= mwait; k++) begin
          if (funct[0]) exp_q.push_back(word(op, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00));
          else          exp_q.push_back(word(op, 0, 0, 0, ok, 1, 0, 2'b00, 2'b00, 2'b00));
          rdy_q.push_back(k == mwait);
        end
        if (funct[0]) begin
          exp_q.push_back(word(op, 0, 0, ok, 0, 0, 0, 2'b00, 2'b01, 2'b00)); rdy_q.push_back(1);
        end
      end
      2'b00: begin
        exec_idx = exp_q.size();
        exp_q.push_back(word(op, 0, 0, 0, 0, 0, 0, funct[5] ? 2'b01 : 2'b00, 2'b00, alu_of(cmd)));
        rdy_q.push_back(1);
        if (cmd != 4'b1010) begin
          wr = ok && legal;
          exp_q.push_back(word(op, wr && (rd == 4'hF), 0, wr, 0, 0, 0, 2'b00, 2'b00, 2'b00));
          rdy_q.push_back(1);
        end
      end
      default: ;
    endcase
    for (int i = 0; i < exp_q.size(); i++) begin
      ALUFlags = (i == exec_idx) ? exec_fl : 4'($urandom);
`ifdef MC_MEMWAIT_EN
      MemReady = rdy_q[i];
`else
      MemReady = 1'($urandom);
`endif
      @(negedge clk);
      check($sformatf("out op=%0d cyc=%0d", op, i), obs, exp_q[i]);
      check($sformatf("flags op=%0d cyc=%0d", op, i), {12'h0, Flags}, {12'h0, model_flags});
      if (i == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_out", obs, word(op, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00));
        check("rst_flags", {12'h0, Flags}, 16'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_flags = 4'h0;
        return;
      end
      @(posedge clk);
      #1;
      if (i == exec_idx && ok && funct[0]) begin
        model_flags[3:2] = exec_fl[3:2];
        if (cmd inside {4'b0100, 4'b0010, 4'b1010}) model_flags[1:0] = exec_fl[1:0];
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out", obs, word(2'b00, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00));
    check("reset_flags", {12'h0, Flags}, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ADDS immediate sets N,Z,C,V from the execute-cycle ALU flags
    run_instr(4'hE, 2'b00, 6'b101001, 4'h1, 4'b0110, 0, 0, -1);
    check("adds_flags", {12'h0, Flags}, 16'h0006);

    // STR aborted by reset in MEMWRITE
    run_instr(4'hE, 2'b01, 6'b011000, 4'h2, 4'h0, 0, 0, 3);
    @(negedge clk);
    check("post_rst_irwrite", {15'h0, IRWrite}, 16'h0001);
    check("post_rst_flags", {12'h0, Flags}, 16'h0000);
    @(posedge clk);
    #1;
    model_flags = 4'h0;
    // The FETCH just checked already advanced; finish this partial instruction as undefined.
    Op = 2'b11;
    ALUFlags = 4'h0;
    @(negedge clk);
    check("undef_decode", obs, word(2'b11, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00));
    @(posedge clk);
    #1;

    // CMP then BEQ taken, BNE not taken
    run_instr(4'hE, 2'b00, 6'b010101, 4'h0, 4'b0100, 0, 0, -1);
    check("cmp_flags", {12'h0, Flags}, 16'h0004);
    run_instr(4'h0, 2'b10, 6'b000000, 4'h0, 4'h0, 0, 0, -1);
    run_instr(4'h1, 2'b10, 6'b000000, 4'h0, 4'h0, 0, 0, -1);

    // LDR
    run_instr(4'hE, 2'b01, 6'b011001, 4'h3, 4'h0, 0, 0, -1);

    // Undefined instruction and NV condition
    run_instr(4'hE, 2'b11, 6'b000000, 4'h0, 4'h0, 0, 0, -1);
    run_instr(4'hF, 2'b00, 6'b001001, 4'h4, 4'hF, 0, 0, -1);

`ifdef MC_MEMWAIT_EN
    run_instr(4'hE, 2'b01, 6'b011000, 4'h5, 4'h0, 0, 3, -1);
    run_instr(4'hE, 2'b01, 6'b011001, 4'h6, 4'h0, 2, 2, -1);
`endif

    // Randomized instruction stream
    for (int t = 0; t < 60; t++) begin
      logic [3:0] rc;
      rc = ($urandom_range(0, 3) == 0) ? 4'(($urandom_range(0, 1) == 0) ? 14 : 15)
                                       : 4'($urandom_range(0, 15));
`ifdef MC_MEMWAIT_EN
      run_instr(rc, 2'($urandom), 6'($urandom), 4'($urandom), 4'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2), -1);
`else
      run_instr(rc, 2'($urandom), 6'($urandom), 4'($urandom), 4'($urandom), 0, 0, -1);
`endif
    end

    @(negedge clk);
    check("final_fetch_irwrite", {15'h0, IRWrite}, 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for the multicycle ARM-subset datapath. It is a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select, and holds the NZCV flag register. Condition codes gate all architectural writes. It sits between the instruction register and the shared ALU, register file, PC and unified memory, and replaces the single-cycle decoder at the top level.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Cond  in  4  IR[31:28]; valid from DECODE onward
- Op  in  2  IR[27:26]
- Funct  in  6  IR[25:20]; [5]=I, [4:1]=cmd, [0]=S (for memory ops, [0]=L)
- Rd  in  4  IR[15:12]
- ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle
- MemReady  in  1  memory access complete
- PCWrite, IRWrite, RegW, MemW, AdrSrc, ALUSrcA  out  1 each
- ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl  out  2 each
- Flags  out  4  current registered {N,Z,C,V}

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Transitions:
  - FETCH→DECODE.
  - From DECODE:
    - Op=01 → MEMADR.
    - Op=00 with I=0 → EXECUTER; with I=1 → EXECUTEI.
    - Op=10 → BRANCH.
    - Op=11 → FETCH (undefined instruction, no writes).
  - MEMADR: L=1 → MEMREAD, L=0 → MEMWRITE.
  - MEMREAD→MEMWB→FETCH. MEMWRITE→FETCH.
  - EXECUTER/EXECUTEI→ALUWB, except CMP, which goes →FETCH. ALUWB→FETCH. BRANCH→FETCH.
- Outputs by state (unlisted outputs are 0):
  - FETCH: AdrSrc=0, IRWrite=1, PCWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=ADD.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=ADD.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWRITE: AdrSrc=1, MemW=CondExReg.
  - MEMWB: ResultSrc=01, RegW=CondExReg.
  - EXECUTER: ALUSrcB=00, ALUControl=decoded.
  - EXECUTEI: ALUSrcB=01, ALUControl=decoded.
  - ALUWB: ResultSrc=00, RegW=CondExReg; PCWrite=CondExReg when Rd=1111.
  - BRANCH: ALUSrcB=01, ResultSrc=10, ALUControl=ADD, PCWrite=CondExReg.
- Decode from Funct[4:1]:
  - ALUControl: 0100 ADD=00, 0010 SUB=01, 1010 CMP=01, 0000 AND=10, 1100 ORR=11. Any other cmd is treated as AND with RegW suppressed.
- Operand selects, combinational in all states: ImmSrc=Op; RegSrc[0]=(Op==10); RegSrc[1]=(Op==01).
- Condition logic:
  - CondEx uses the standard ARM table (EQ..AL) over the registered Flags. Cond=1111 gives CondEx=0.
  - CondExReg latches CondEx at the end of DECODE and is used for all gating in that instruction.
- Flag update at the end of EXECUTER/EXECUTEI, only when CondExReg=1:
  - If S=1: N,Z ← ALUFlags[3:2].
  - If S=1 and cmd is ADD, SUB or CMP: C,V ← ALUFlags[1:0].

## Timing
- Cycles per instruction (no wait states):
  - LDR 5; STR 4.
  - Data-processing 4; CMP 3.
  - Branch 3; undefined 2.
- A failed condition does not shorten the sequence. The instruction traverses the same states with its writes suppressed.
- Reset (async assert, sync release):
  - State=FETCH, Flags=0000, CondExReg=0.
  - While rst_n=0, PCWrite, IRWrite, RegW and MemW are forced to 0; all other outputs carry FETCH values.
- Reset mid-instruction aborts the instruction immediately. No write occurs in the reset cycle.
- Flags written at the end of EXECUTE are visible to the next instruction's DECODE.

## Configuration
- MC_MEMWAIT_EN defined:
  - FETCH, MEMREAD and MEMWRITE hold while MemReady=0.
  - In FETCH, IRWrite and PCWrite are asserted only in the cycle where MemReady=1.
  - In MEMWRITE, MemW stays asserted until MemReady=1.
- MC_MEMWAIT_EN undefined: each state lasts exactly one cycle and MemReady is ignored. The port remains present in both builds.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum;
  - Op codes (DP=00, MEM=01, BR=10);
  - cmd codes, ALUControl codes, ResultSrc and ALUSrcB encodings;
  - cond code constants.
- Sub-module cond_unit holds the Flags register, the CondEx table and CondExReg. Its inputs are clk, rst_n, Cond, ALUFlags, the flag-write strobes and the latch strobe.

## Test plan
- Reset low mid-MEMWRITE → MemW=0 at once. After release: state FETCH, Flags=0000, IRWrite=1.
- ADDS with Op=00, Funct=101001 and ALUFlags=0110 in EXECUTEI:
  - states FETCH, DECODE, EXECUTEI, ALUWB;
  - RegW=1 in ALUWB;
  - Flags=0110 afterwards.
- CMP with Funct=010101 and ALUFlags=0100, then BEQ (Cond=0000, Op=10):
  - CMP takes 3 cycles with no RegW;
  - BEQ asserts PCWrite=1 in BRANCH.
- BNE (Cond=0001) with Z=1 → BRANCH is entered with PCWrite=0.
- LDR with Op=01 and Funct=011001 → states MEMADR, MEMREAD, MEMWB; ResultSrc=01 and RegW=1 in MEMWB.
- With MC_MEMWAIT_EN, an STR where MemReady is low for 3 cycles → MemW stays high for 4 cycles and the FSM returns to FETCH after the ready cycle.
